// File: rtl/traffic_light_sequencer.sv
// Two-way intersection phase sequencer driving an external saturation counter as its phase timer.
// Outputs registered; each phase lasts duration+2 cycles; no backpressure (pedestrian request is latched).
module traffic_light_sequencer #(
    parameter int COUNT_SIZE  = 5,
    parameter int T_GREEN     = 8,
    parameter int T_YELLOW    = 3,
    parameter int T_RED       = 2,
    parameter int T_MIN_GREEN = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ped_req,
    input  logic [COUNT_SIZE-1:0] cnt,
    output logic                  cnt_rst,
    output logic                  cnt_up,
    output logic                  cnt_down,
    output logic                  cnt_load,
    output logic [1:0]            cnt_load_max,
    output logic [COUNT_SIZE-1:0] cnt_max_in,
    output logic [2:0]            ns_light,
    output logic [2:0]            ew_light,
    output logic                  walk
);

    typedef enum logic [2:0] {
        RED_A, NS_GREEN, NS_YELLOW, RED_B, EW_GREEN, EW_YELLOW
    } state_e;

    localparam logic [COUNT_SIZE-1:0] D_GREEN     = COUNT_SIZE'(T_GREEN);
    localparam logic [COUNT_SIZE-1:0] D_YELLOW    = COUNT_SIZE'(T_YELLOW);
    localparam logic [COUNT_SIZE-1:0] D_RED       = COUNT_SIZE'(T_RED);
    localparam logic [COUNT_SIZE-1:0] D_MIN_GREEN = COUNT_SIZE'(T_MIN_GREEN);

    localparam logic [2:0] L_RED    = 3'b100;
    localparam logic [2:0] L_YELLOW = 3'b010;
    localparam logic [2:0] L_GREEN  = 3'b001;

    function automatic logic [COUNT_SIZE-1:0] dur(input state_e s);
        case (s)
            NS_GREEN, EW_GREEN:   dur = D_GREEN;
            NS_YELLOW, EW_YELLOW: dur = D_YELLOW;
            default:              dur = D_RED;
        endcase
    endfunction

    function automatic state_e next_state(input state_e s);
        case (s)
            RED_A:     next_state = NS_GREEN;
            NS_GREEN:  next_state = NS_YELLOW;
            NS_YELLOW: next_state = RED_B;
            RED_B:     next_state = EW_GREEN;
            EW_GREEN:  next_state = EW_YELLOW;
            default:   next_state = RED_A;
        endcase
    endfunction

    // {ns, ew} lamp decode; only one direction can ever be non-red
    function automatic logic [5:0] lamps(input state_e s);
        case (s)
            NS_GREEN:  lamps = {L_GREEN, L_RED};
            NS_YELLOW: lamps = {L_YELLOW, L_RED};
            EW_GREEN:  lamps = {L_RED, L_GREEN};
            EW_YELLOW: lamps = {L_RED, L_YELLOW};
            default:   lamps = {L_RED, L_RED};
        endcase
    endfunction

    state_e                  state_q, state_d;
    logic                    setup_q, setup_d;
    logic                    ped_pending_q, ped_pending_d;
    logic                    walk_en_q, walk_en_d;
    logic [COUNT_SIZE-1:0]   limit;
    logic                    cnt_rst_q, cnt_rst_d;
    logic                    cnt_up_q, cnt_up_d;
    logic [1:0]              cnt_load_max_q, cnt_load_max_d;
    logic [COUNT_SIZE-1:0]   cnt_max_in_q, cnt_max_in_d;
    logic [2:0]              ns_light_q, ns_light_d;
    logic [2:0]              ew_light_q, ew_light_d;

    always_comb begin
        state_d       = state_q;
        setup_d       = setup_q;
        ped_pending_d = ped_pending_q | ped_req;
        walk_en_d     = walk_en_q;

        limit = dur(state_q);
        if (state_q == NS_GREEN && ped_pending_q)
            limit = D_MIN_GREEN;

        if (setup_q) begin
            setup_d = 1'b0;
            // a request arriving on the clearing cycle is kept for the next round
            if (state_q == EW_GREEN)
                ped_pending_d = ped_req;
        end else if (cnt >= limit) begin
            state_d = next_state(state_q);
            setup_d = 1'b1;
        end

        // walk_en takes the latch value the EW_GREEN SETUP cycle will see
        if (state_d == EW_GREEN && setup_d && !(state_q == EW_GREEN && setup_q))
            walk_en_d = ped_pending_d;
        else if (state_d != EW_GREEN)
            walk_en_d = 1'b0;

        cnt_rst_d      = setup_d;
        cnt_up_d       = ~setup_d;
        cnt_load_max_d = setup_d ? 2'b10 : 2'b01;
        cnt_max_in_d   = dur(state_d);
        {ns_light_d, ew_light_d} = lamps(state_d);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= RED_A;
            setup_q        <= 1'b1;
            ped_pending_q  <= 1'b0;
            walk_en_q      <= 1'b0;
            cnt_rst_q      <= 1'b1;
            cnt_up_q       <= 1'b0;
            cnt_load_max_q <= 2'b10;
            cnt_max_in_q   <= D_RED;
            ns_light_q     <= L_RED;
            ew_light_q     <= L_RED;
        end else begin
            state_q        <= state_d;
            setup_q        <= setup_d;
            ped_pending_q  <= ped_pending_d;
            walk_en_q      <= walk_en_d;
            cnt_rst_q      <= cnt_rst_d;
            cnt_up_q       <= cnt_up_d;
            cnt_load_max_q <= cnt_load_max_d;
            cnt_max_in_q   <= cnt_max_in_d;
            ns_light_q     <= ns_light_d;
            ew_light_q     <= ew_light_d;
        end
    end

    assign cnt_rst      = cnt_rst_q;
    assign cnt_up       = cnt_up_q;
    assign cnt_down     = 1'b0;
    assign cnt_load     = 1'b0;
    assign cnt_load_max = cnt_load_max_q;
    assign cnt_max_in   = cnt_max_in_q;
    assign ns_light     = ns_light_q;
    assign ew_light     = ew_light_q;
    assign walk         = walk_en_q;

endmodule

// File: tb/tb_traffic_light_sequencer.sv
// Directed bench for traffic_light_sequencer with a behavioural saturation counter in the loop.
module tb_traffic_light_sequencer;

    localparam int CS = 5;
    localparam logic [2:0] R = 3'b100;
    localparam logic [2:0] Y = 3'b010;
    localparam logic [2:0] G = 3'b001;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          ped_req = 1'b0;
    logic [CS-1:0] cnt;
    logic          cnt_rst, cnt_up, cnt_down, cnt_load, walk;
    logic [1:0]    cnt_load_max;
    logic [CS-1:0] cnt_max_in;
    logic [2:0]    ns_light, ew_light;

    int checks = 0;
    int errors = 0;
    bit mon_en = 1'b0;
    bit force_en = 1'b0;

    logic [CS-1:0] cnt_model = '0;
    logic [CS-1:0] max_model = '0;

    traffic_light_sequencer dut (
        .clk(clk), .rst(rst), .ped_req(ped_req), .cnt(cnt),
        .cnt_rst(cnt_rst), .cnt_up(cnt_up), .cnt_down(cnt_down), .cnt_load(cnt_load),
        .cnt_load_max(cnt_load_max), .cnt_max_in(cnt_max_in),
        .ns_light(ns_light), .ew_light(ew_light), .walk(walk)
    );

    always #5 clk = ~clk;

    // Saturation counter: clear, load max, count up saturating at max
    always @(posedge clk) begin
        if (cnt_rst === 1'b1)
            cnt_model <= '0;
        else if (cnt_up === 1'b1 && cnt_model < max_model)
            cnt_model <= cnt_model + 1'b1;
        if (cnt_load_max === 2'b10)
            max_model <= cnt_max_in;
    end

    assign cnt = force_en ? 5'd31 : cnt_model;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            chk("ns_onehot", int'($onehot(ns_light)), 1);
            chk("ew_onehot", int'($onehot(ew_light)), 1);
            chk("no_dual_green", int'(ns_light[0] & ew_light[0]), 0);
            chk("cnt_down_zero", int'(cnt_down), 0);
            chk("cnt_load_zero", int'(cnt_load), 0);
        end
    end

    // Entered on the SETUP cycle of a phase; returns on the first cycle of the next phase
    task automatic expect_phase(input string tag, input logic [2:0] ns_e, input logic [2:0] ew_e,
                                input int len_e, input int max_e, input logic walk_e, input bit drop_ped);
        int len;
        bit walk_bad;
        bit max_bad;
        chk({tag, "_ns"}, int'(ns_light), int'(ns_e));
        chk({tag, "_ew"}, int'(ew_light), int'(ew_e));
        chk({tag, "_setup_rst"}, int'(cnt_rst), 1);
        chk({tag, "_setup_up"}, int'(cnt_up), 0);
        chk({tag, "_setup_ldmax"}, int'(cnt_load_max), 2);
        chk({tag, "_max_in"}, int'(cnt_max_in), max_e);
        chk({tag, "_setup_walk"}, int'(walk), int'(walk_e));
        len = 1;
        walk_bad = 1'b0;
        max_bad = 1'b0;
        tick();
        if (drop_ped) ped_req = 1'b0;
        chk({tag, "_run_rst"}, int'(cnt_rst), 0);
        chk({tag, "_run_up"}, int'(cnt_up), 1);
        chk({tag, "_run_ldmax"}, int'(cnt_load_max), 1);
        while (ns_light === ns_e && ew_light === ew_e && len < 40) begin
            if (walk !== walk_e) walk_bad = 1'b1;
            if (cnt_max_in !== CS'(max_e)) max_bad = 1'b1;
            len++;
            tick();
        end
        chk({tag, "_len"}, len, len_e);
        chk({tag, "_walk_run"}, int'(walk_bad), 0);
        chk({tag, "_max_run"}, int'(max_bad), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset for 2 cycles, then the reset-state SETUP cycle is visible
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        mon_en = 1'b1;

        // Round 1: no pedestrian
        expect_phase("r1_red_a", R, R, 4, 2, 1'b0, 1'b0);
        expect_phase("r1_ns_g",  G, R, 10, 8, 1'b0, 1'b0);
        expect_phase("r1_ns_y",  Y, R, 5, 3, 1'b0, 1'b0);
        expect_phase("r1_red_b", R, R, 4, 2, 1'b0, 1'b0);
        expect_phase("r1_ew_g",  R, G, 10, 8, 1'b0, 1'b0);
        expect_phase("r1_ew_y",  R, Y, 5, 3, 1'b0, 1'b0);

        // Round 2: 1-cycle pulse at cnt=1 cuts NS green at cnt=4
        expect_phase("r2_red_a", R, R, 4, 2, 1'b0, 1'b0);
        chk("cut_setup_ns", int'(ns_light), int'(G));
        chk("cut_setup_rst", int'(cnt_rst), 1);
        tick();
        chk("cut_cnt0", int'(cnt), 0);
        tick();
        chk("cut_cnt1", int'(cnt), 1);
        ped_req = 1'b1;
        tick();
        ped_req = 1'b0;
        tick();
        tick();
        chk("cut_last_cnt", int'(cnt), 4);
        chk("cut_last_ns", int'(ns_light), int'(G));
        tick();
        chk("cut_next_ns", int'(ns_light), int'(Y));
        expect_phase("r2_ns_y",  Y, R, 5, 3, 1'b0, 1'b0);
        expect_phase("r2_red_b", R, R, 4, 2, 1'b0, 1'b0);
        expect_phase("r2_ew_g",  R, G, 10, 8, 1'b1, 1'b0);
        expect_phase("r2_ew_y",  R, Y, 5, 3, 1'b0, 1'b0);

        // Round 3: latch was cleared, then ped_req held across the EW_GREEN SETUP cycle
        expect_phase("r3_red_a", R, R, 4, 2, 1'b0, 1'b0);
        expect_phase("r3_ns_g",  G, R, 10, 8, 1'b0, 1'b0);
        expect_phase("r3_ns_y",  Y, R, 5, 3, 1'b0, 1'b0);
        ped_req = 1'b1;
        expect_phase("r3_red_b", R, R, 4, 2, 1'b0, 1'b0);
        expect_phase("r3_ew_g",  R, G, 10, 8, 1'b1, 1'b1);
        expect_phase("r3_ew_y",  R, Y, 5, 3, 1'b0, 1'b0);
        expect_phase("r4_red_a", R, R, 4, 2, 1'b0, 1'b0);
        expect_phase("r4_ns_g_cut", G, R, 6, 8, 1'b0, 1'b0);

        // Reset mid NS_YELLOW RUN at cnt=2
        chk("rst_pre_ns", int'(ns_light), int'(Y));
        tick();
        tick();
        tick();
        chk("rst_pre_cnt", int'(cnt), 2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_ns", int'(ns_light), int'(R));
        chk("rst_ew", int'(ew_light), int'(R));
        chk("rst_max_in", int'(cnt_max_in), 2);
        chk("rst_cnt_rst", int'(cnt_rst), 1);
        chk("rst_walk", int'(walk), 0);
        tick();
        chk("rst_cnt_cleared", int'(cnt), 0);
        chk("rst_run_rst", int'(cnt_rst), 0);
        chk("rst_run_ns", int'(ns_light), int'(R));

        // Counter bypassed to 31 during RED_A RUN: advance on the next edge
        force_en = 1'b1;
        tick();
        force_en = 1'b0;
        chk("force_adv_ns", int'(ns_light), int'(G));
        chk("force_adv_setup", int'(cnt_rst), 1);
        // Reset cleared the pending request, so this green runs full length
        expect_phase("post_rst_ns_g", G, R, 10, 8, 1'b0, 1'b0);
        expect_phase("post_rst_ns_y", Y, R, 5, 3, 1'b0, 1'b0);

        mon_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
